// File: rtl/idli_ex_ser_if.sv
// Bundles the decode-side op handshake, the per-beat PC/immediate feed and
// the write-back/status outputs of the serial execution unit.
//
// Op handshake: i_ex_op_vld is the valid, o_ex_op_acp is the ready. An op
// transfers on a cycle where both are high. The source holds the op fields
// stable while valid is high and ready is low. o_ex_op_acp may be high
// without a valid, meaning the unit is free to take an op.
interface idli_ex_ser_if #(
  parameter int BEAT_W = 4,
  parameter int RIDX_W = 4
);
  logic              i_ex_op_vld;
  logic              o_ex_op_acp;
  logic [2:0]        i_ex_alu_op;
  logic              i_ex_rhs_inv;
  logic              i_ex_cin;
  logic [RIDX_W-1:0] i_ex_a;
  logic              i_ex_a_vld;
  logic [RIDX_W-1:0] i_ex_b;
  logic [RIDX_W-1:0] i_ex_c;
  logic [1:0]        i_ex_lhs_src;
  logic              i_ex_rhs_src;
  logic              i_ex_flags_upd;
  logic [BEAT_W-1:0] i_ex_pc;
  logic [BEAT_W-1:0] i_ex_imm;
  logic              i_ex_imm_vld;
  logic              o_ex_wr_vld;
  logic [RIDX_W-1:0] o_ex_wr_reg;
  logic [BEAT_W-1:0] o_ex_wr_data;
  logic              o_ex_done;
  logic [3:0]        o_ex_flags;

  modport master (
    output i_ex_op_vld, i_ex_alu_op, i_ex_rhs_inv, i_ex_cin, i_ex_a, i_ex_a_vld,
           i_ex_b, i_ex_c, i_ex_lhs_src, i_ex_rhs_src, i_ex_flags_upd,
           i_ex_pc, i_ex_imm, i_ex_imm_vld,
    input  o_ex_op_acp, o_ex_wr_vld, o_ex_wr_reg, o_ex_wr_data, o_ex_done, o_ex_flags
  );

  modport slave (
    input  i_ex_op_vld, i_ex_alu_op, i_ex_rhs_inv, i_ex_cin, i_ex_a, i_ex_a_vld,
           i_ex_b, i_ex_c, i_ex_lhs_src, i_ex_rhs_src, i_ex_flags_upd,
           i_ex_pc, i_ex_imm, i_ex_imm_vld,
    output o_ex_op_acp, o_ex_wr_vld, o_ex_wr_reg, o_ex_wr_data, o_ex_done, o_ex_flags
  );
endinterface

// File: rtl/idli_ex_ser_m.sv
// Beat-serial execution unit: runs one ALU op over DATA_W/BEAT_W beats, LSB
// slice first, chaining carry between beats, against its own register file.
// Condition flags {N,Z,C,V} are built only when IDLI_EX_SER_FLAGS_EN is
// defined; otherwise o_ex_flags reads as zero.
module idli_ex_ser_m #(
  parameter int DATA_W   = 16,
  parameter int BEAT_W   = 4,
  parameter int NUM_REGS = 16
) (
  input logic          i_ex_gck,
  input logic          i_ex_rst_n,
  idli_ex_ser_if.slave ex
);
  localparam int RIDX_W = $clog2(NUM_REGS);
  localparam int BEATS  = DATA_W / BEAT_W;
  localparam int CTR_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(BEATS - 1);
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;

  typedef struct packed {
    logic [2:0]        alu_op;
    logic              rhs_inv;
    logic              cin;
    logic [RIDX_W-1:0] a;
    logic              a_vld;
    logic [RIDX_W-1:0] b;
    logic [RIDX_W-1:0] c;
    logic [1:0]        lhs_src;
    logic              rhs_src;
    logic              flags_upd;
  } op_t;

  op_t              op_q, op_d;
  logic             op_vld_q, op_vld_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             carry_q, carry_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              adv, last, acp, cin, cout;
  logic [DATA_W-1:0] lhs_word, rhs_word;
  logic [BEAT_W-1:0] lhs, rhs, res;
  logic [BEAT_W:0]   sum;

  // Beat datapath: operand select, ALU and progress/accept control.
  always_comb begin
    adv      = op_vld_q && (!op_q.rhs_src || ex.i_ex_imm_vld);
    last     = adv && (ctr_q == CTR_LAST);
    acp      = !op_vld_q || last;
    lhs_word = regs_q[op_q.b];
    rhs_word = regs_q[op_q.c];
    lhs      = '0;
    case (op_q.lhs_src)
      2'd0:    lhs = lhs_word[ctr_q*BEAT_W +: BEAT_W];
      2'd2:    lhs = ex.i_ex_pc;
      default: lhs = '0;
    endcase
    rhs = op_q.rhs_src ? ex.i_ex_imm : rhs_word[ctr_q*BEAT_W +: BEAT_W];
    if (op_q.rhs_inv) rhs = ~rhs;
    cin  = (ctr_q == '0) ? op_q.cin : carry_q;
    sum  = {1'b0, lhs} + {1'b0, rhs} + {{BEAT_W{1'b0}}, cin};
    cout = sum[BEAT_W];
    case (op_q.alu_op)
      ALU_ADD: res = sum[BEAT_W-1:0];
      ALU_AND: res = lhs & rhs;
      ALU_OR:  res = lhs | rhs;
      ALU_XOR: res = lhs ^ rhs;
      default: res = rhs;
    endcase
  end

  // Next-state for op latch, beat counter and inter-beat carry.
  always_comb begin
    op_d     = op_q;
    op_vld_d = op_vld_q;
    ctr_d    = ctr_q;
    carry_d  = carry_q;
    if (acp) begin
      op_vld_d          = ex.i_ex_op_vld;
      op_d.alu_op       = ex.i_ex_alu_op;
      op_d.rhs_inv      = ex.i_ex_rhs_inv;
      op_d.cin          = ex.i_ex_cin;
      op_d.a            = ex.i_ex_a;
      op_d.a_vld        = ex.i_ex_a_vld;
      op_d.b            = ex.i_ex_b;
      op_d.c            = ex.i_ex_c;
      op_d.lhs_src      = ex.i_ex_lhs_src;
      op_d.rhs_src      = ex.i_ex_rhs_src;
      op_d.flags_upd    = ex.i_ex_flags_upd;
    end
    if (adv) begin
      ctr_d   = (ctr_q == CTR_LAST) ? '0 : ctr_q + 1'b1;
      carry_d = cout;
    end
  end

  // Control state; reset aborts any op in flight.
  always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      op_q     <= '0;
      op_vld_q <= 1'b0;
      ctr_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      op_q     <= op_d;
      op_vld_q <= op_vld_d;
      ctr_q    <= ctr_d;
      carry_q  <= carry_d;
    end
  end

  // Register file slice write; reads above see the pre-write value.
  always_ff @(posedge i_ex_gck) begin
    if (adv && op_q.a_vld) regs_q[op_q.a][ctr_q*BEAT_W +: BEAT_W] <= res;
  end

  assign ex.o_ex_op_acp  = acp;
  assign ex.o_ex_wr_vld  = adv && op_q.a_vld;
  assign ex.o_ex_wr_reg  = (adv && op_q.a_vld) ? op_q.a : '0;
  assign ex.o_ex_wr_data = (adv && op_q.a_vld) ? res : '0;
  assign ex.o_ex_done    = last;

`ifdef IDLI_EX_SER_FLAGS_EN
  logic       z_acc_q, z_acc_d;
  logic [3:0] flags_q, flags_d;

  // Zero accumulation across beats and end-of-op flag commit.
  always_comb begin
    z_acc_d = z_acc_q;
    flags_d = flags_q;
    if (adv) z_acc_d = ((ctr_q == '0) ? 1'b1 : z_acc_q) && (res == '0);
    if (last && op_q.flags_upd) begin
      flags_d[3] = res[BEAT_W-1];
      flags_d[2] = z_acc_d;
      if (op_q.alu_op == ALU_ADD) begin
        flags_d[1] = cout;
        flags_d[0] = (lhs[BEAT_W-1] == rhs[BEAT_W-1]) && (res[BEAT_W-1] != lhs[BEAT_W-1]);
      end
    end
  end

  // Flag state register.
  always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      z_acc_q <= 1'b0;
      flags_q <= '0;
    end else begin
      z_acc_q <= z_acc_d;
      flags_q <= flags_d;
    end
  end

  assign ex.o_ex_flags = flags_q;
`else
  logic unused_flags_upd;
  assign unused_flags_upd = op_q.flags_upd;
  assign ex.o_ex_flags    = '0;
`endif
endmodule

// File: tb/tb_idli_ex_ser_m.sv
// Directed bench for idli_ex_ser_m (16-bit data, 4-bit beats, 16 registers).
module tb_idli_ex_ser_m;
  localparam int DATA_W = 16;
  localparam int BEAT_W = 4;
  localparam int NUM_REGS = 16;
  localparam int RIDX_W = 4;
  localparam int BEATS = DATA_W / BEAT_W;
  localparam int EW = RIDX_W + BEAT_W + 1;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idli_ex_ser_if #(.BEAT_W(BEAT_W), .RIDX_W(RIDX_W)) ex_if ();

  idli_ex_ser_m #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .NUM_REGS(NUM_REGS)) dut (
    .i_ex_gck  (clk),
    .i_ex_rst_n(rst_n),
    .ex        (ex_if)
  );

  typedef struct {
    logic [2:0]  alu;
    logic        inv;
    logic        cin;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  c;
    logic [1:0]  lsrc;
    logic        rsrc;
    logic        fupd;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [15:0] exp;
    logic [3:0]  flags;
    int          stall_beat;
    int          stall_n;
  } op_t;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [3:0] exp_flags_now = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] fl(input logic [3:0] f);
`ifdef IDLI_EX_SER_FLAGS_EN
    return f;
`else
    return 4'h0 & f;
`endif
  endfunction

  function automatic op_t mk(input logic [2:0] alu, input logic inv, input logic cin,
                             input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                             input logic [1:0] lsrc, input logic rsrc, input logic fupd,
                             input logic [15:0] imm, input logic [15:0] pc,
                             input logic [15:0] exp, input logic [3:0] flags);
    op_t o;
    o.alu = alu; o.inv = inv; o.cin = cin; o.a = a; o.b = b; o.c = c;
    o.lsrc = lsrc; o.rsrc = rsrc; o.fupd = fupd; o.imm = imm; o.pc = pc;
    o.exp = exp; o.flags = flags; o.stall_beat = -1; o.stall_n = 0;
    return o;
  endfunction

  function automatic op_t ld(input logic [3:0] r, input logic [15:0] v);
    return mk(3'd4, 1'b0, 1'b0, r, 4'd0, 4'd0, 2'd1, 1'b1, 1'b0, v, 16'h0, v, 4'h0);
  endfunction

  // Driver tasks
  task automatic drive_fields(input op_t o);
    ex_if.i_ex_alu_op    = o.alu;
    ex_if.i_ex_rhs_inv   = o.inv;
    ex_if.i_ex_cin       = o.cin;
    ex_if.i_ex_a         = o.a;
    ex_if.i_ex_a_vld     = 1'b1;
    ex_if.i_ex_b         = o.b;
    ex_if.i_ex_c         = o.c;
    ex_if.i_ex_lhs_src   = o.lsrc;
    ex_if.i_ex_rhs_src   = o.rsrc;
    ex_if.i_ex_flags_upd = o.fupd;
  endtask

  task automatic push_exp(input op_t o, input int nbeats);
    for (int k = 0; k < nbeats; k++)
      exp_q.push_back({o.a, o.exp[k*BEAT_W +: BEAT_W], 1'(k == BEATS - 1)});
  endtask

  task automatic accept(input op_t o, input int nbeats);
    drive_fields(o);
    ex_if.i_ex_op_vld = 1'b1;
    push_exp(o, nbeats);
    @(negedge clk);
    check("acp_idle", ex_if.o_ex_op_acp, 1);
    @(posedge clk); #1;
    ex_if.i_ex_op_vld = 1'b0;
  endtask

  task automatic feed(input op_t o, input bit has_next, input op_t nxt, input int abort_at);
    for (int k = 0; k < BEATS; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        ex_if.i_ex_imm_vld = 1'b0;
        #1;
        check("rst_acp", ex_if.o_ex_op_acp, 1);
        check("rst_wr_vld", ex_if.o_ex_wr_vld, 0);
        check("rst_done", ex_if.o_ex_done, 0);
        check("rst_flags", ex_if.o_ex_flags, 0);
        exp_flags_now = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (k == o.stall_beat) begin
        repeat (o.stall_n) begin
          ex_if.i_ex_imm_vld = 1'b0;
          ex_if.i_ex_imm = '0;
          ex_if.i_ex_op_vld = 1'b0;
          @(negedge clk);
          check("acp_stall", ex_if.o_ex_op_acp, 0);
          @(posedge clk); #1;
        end
      end
      ex_if.i_ex_imm = o.imm[k*BEAT_W +: BEAT_W];
      ex_if.i_ex_pc = o.pc[k*BEAT_W +: BEAT_W];
      ex_if.i_ex_imm_vld = 1'b1;
      if (k == BEATS - 1 && has_next) begin
        drive_fields(nxt);
        ex_if.i_ex_op_vld = 1'b1;
        push_exp(nxt, BEATS);
      end else begin
        ex_if.i_ex_op_vld = 1'b0;
      end
      @(negedge clk);
      check("acp_beat", ex_if.o_ex_op_acp, 32'(k == BEATS - 1));
      @(posedge clk); #1;
    end
    ex_if.i_ex_op_vld = 1'b0;
    ex_if.i_ex_imm_vld = 1'b0;
    if (o.fupd) exp_flags_now = o.flags;
    check("flags", ex_if.o_ex_flags, fl(exp_flags_now));
  endtask

  task automatic run(input op_t o);
    accept(o, BEATS);
    feed(o, 1'b0, o, -1);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every write-back beat pops one expected entry
  always @(negedge clk) begin
    if (ex_if.o_ex_wr_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got reg %0d data 0x%0h, none required", ex_if.o_ex_wr_reg, ex_if.o_ex_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_beat", {ex_if.o_ex_wr_reg, ex_if.o_ex_wr_data, ex_if.o_ex_done}, mon_e);
      end
    end else if (ex_if.o_ex_done) begin
      check("done_without_wb", ex_if.o_ex_done, 0);
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    op_t o, p;
    ex_if.i_ex_op_vld = 0; ex_if.i_ex_alu_op = 0; ex_if.i_ex_rhs_inv = 0; ex_if.i_ex_cin = 0;
    ex_if.i_ex_a = 0; ex_if.i_ex_a_vld = 0; ex_if.i_ex_b = 0; ex_if.i_ex_c = 0;
    ex_if.i_ex_lhs_src = 0; ex_if.i_ex_rhs_src = 0; ex_if.i_ex_flags_upd = 0;
    ex_if.i_ex_pc = 0; ex_if.i_ex_imm = 0; ex_if.i_ex_imm_vld = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_acp", ex_if.o_ex_op_acp, 1);
    check("reset_wr_vld", ex_if.o_ex_wr_vld, 0);
    check("reset_wr_reg", ex_if.o_ex_wr_reg, 0);
    check("reset_wr_data", ex_if.o_ex_wr_data, 0);
    check("reset_done", ex_if.o_ex_done, 0);
    check("reset_flags", ex_if.o_ex_flags, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD r3 = r1 + r2 = 0x00FF + 0x0001
    run(ld(4'd1, 16'h00FF));
    run(ld(4'd2, 16'h0001));
    run(mk(3'd0, 1'b0, 1'b0, 4'd3, 4'd1, 4'd2, 2'd0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0100, 4'b0000));
    // SUB r4 = r5 - r5
    run(ld(4'd5, 16'h0005));
    run(mk(3'd0, 1'b1, 1'b1, 4'd4, 4'd5, 4'd5, 2'd0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0000, 4'b0110));
    // ADD r6 = r2 + imm 0x0FFF, immediate stalled 3 cycles before beat 2
    o = mk(3'd0, 1'b0, 1'b0, 4'd6, 4'd2, 4'd0, 2'd0, 1'b1, 1'b1, 16'h0FFF, 16'h0, 16'h1000, 4'b0000);
    o.stall_beat = 2;
    o.stall_n = 3;
    run(o);
    // Back-to-back: ADD r1 = r1 + 1 (0x7FFF), then AND r2 = r1 & r1
    run(ld(4'd1, 16'h7FFF));
    o = mk(3'd0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd0, 2'd0, 1'b1, 1'b1, 16'h0001, 16'h0, 16'h8000, 4'b1001);
    p = mk(3'd1, 1'b0, 1'b0, 4'd2, 4'd1, 4'd1, 2'd0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h8000, 4'b1001);
    accept(o, BEATS);
    feed(o, 1'b1, p, -1);
    feed(p, 1'b0, p, -1);
    @(posedge clk); #1;
    // OR r7 = PC | imm, XOR r8 = r7 ^ r7
    run(mk(3'd2, 1'b0, 1'b0, 4'd7, 4'd0, 4'd0, 2'd2, 1'b1, 1'b1, 16'h0A05, 16'hA050, 16'hAA55, 4'b1001));
    run(mk(3'd3, 1'b0, 1'b0, 4'd8, 4'd7, 4'd7, 2'd0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0000, 4'b0101));
    // Reserved ALU code acts as PASS_RHS; reserved LHS source acts as zero
    run(mk(3'd5, 1'b0, 1'b0, 4'd9, 4'd1, 4'd0, 2'd0, 1'b1, 1'b0, 16'h5A5A, 16'h0, 16'h5A5A, 4'h0));
    run(mk(3'd0, 1'b0, 1'b0, 4'd10, 4'd1, 4'd0, 2'd3, 1'b1, 1'b0, 16'h0F0F, 16'h0, 16'h0F0F, 4'h0));
    // r13 = r10 - imm 0x0F00
    run(mk(3'd0, 1'b1, 1'b1, 4'd13, 4'd10, 4'd0, 2'd0, 1'b1, 1'b1, 16'h0F00, 16'h0, 16'h000F, 4'b0010));
    // Reset at beat 2 of ADD r11 = r1 + r2: only beats 0 and 1 write
    o = mk(3'd0, 1'b0, 1'b0, 4'd11, 4'd1, 4'd2, 2'd0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0000, 4'b0110);
    accept(o, 2);
    feed(o, 1'b0, o, 2);
    check("post_rst_acp", ex_if.o_ex_op_acp, 1);
    check("post_rst_flags", ex_if.o_ex_flags, 0);
    // Recovery: ADD r12 = r2 + r7 = 0x8000 + 0xAA55
    run(mk(3'd0, 1'b0, 1'b0, 4'd12, 4'd2, 4'd7, 2'd0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h2A55, 4'b0011));

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
